sap2_control_sequencer: RTL and testbench

- Consumes the 18-bit one-hot T-state vector from the SAP-2 ring counter (T0..T17) and the 8-bit opcode held in the instruction register.
- Produces a registered control word for the datapath and a one-cycle ring restart request at the last T-state of each instruction, so instructions have variable length.
- Also tracks HLT and illegal opcodes and counts retired instructions.
- Sits directly downstream of the ring counter and feeds every datapath load/enable strobe.

---
 rtl/sap2_ctrl_pkg.sv | 101 ++++++++++
 rtl/sap2_tstate_encoder.sv | 21 ++
 rtl/sap2_control_sequencer.sv | 120 ++++++++++++
 tb/tb_sap2_control_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sap2_ctrl_pkg.sv
// SAP-2 control sequencer shared definitions: control-bit positions, opcodes,
// instruction lengths and the per-T-state control word table.
package sap2_ctrl_pkg;

   localparam int EP   = 15;
   localparam int CP   = 14;
   localparam int LM   = 13;
   localparam int CE   = 12;
   localparam int LI   = 11;
   localparam int EI   = 10;
   localparam int LA   = 9;
   localparam int EA   = 8;
   localparam int SU   = 7;
   localparam int EU   = 6;
   localparam int LB   = 5;
   localparam int LC   = 4;
   localparam int LT   = 3;
   localparam int LO   = 2;
   localparam int LMDR = 1;
   localparam int EMDR = 0;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_ADDB = 8'h80;
   localparam logic [7:0] OP_HLT  = 8'h76;
   localparam logic [7:0] OP_MVIA = 8'h3E;
   localparam logic [7:0] OP_JMP  = 8'hC3;
   localparam logic [7:0] OP_OUT  = 8'hD3;

   typedef enum logic [1:0] {sRun, sHalt, sFault} seqState_e;

   function automatic logic [15:0] cb(input int idx);
      return 16'h0001 << idx;
   endfunction

   function automatic logic isKnownOp(input logic [7:0] op);
      case (op)
         OP_NOP, OP_ADDB, OP_HLT, OP_MVIA, OP_JMP, OP_OUT: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [4:0] instrLen(input logic [7:0] op);
      case (op)
         OP_HLT:         return 5'd5;
         OP_MVIA:        return 5'd7;
         OP_JMP, OP_OUT: return 5'd10;
         default:        return 5'd4;
      endcase
   endfunction

   // Execute-phase words; any T-index past the opcode's length falls to 0.
   function automatic logic [15:0] execWord(input logic [7:0] op, input logic [4:0] t);
      logic [15:0] w;
      w = '0;
      case (op)
         OP_ADDB: if (t == 5'd3) w = cb(EU) | cb(LA);
         OP_MVIA:
            case (t)
               5'd3: w = cb(EP) | cb(LM);
               5'd4: w = cb(CE) | cb(LMDR);
               5'd5: w = cb(CP);
               5'd6: w = cb(EMDR) | cb(LA);
               default: w = '0;
            endcase
         OP_JMP:
            case (t)
               5'd3: w = cb(EP) | cb(LM);
               5'd4: w = cb(CP);
               5'd5: w = cb(CE) | cb(LMDR);
               5'd6: w = cb(EP) | cb(LM);
               5'd7: w = cb(CP);
               5'd8: w = cb(CE) | cb(LT);
               5'd9: w = cb(EMDR) | cb(EI);
               default: w = '0;
            endcase
         OP_OUT:
            case (t)
               5'd3: w = cb(EP) | cb(LM);
               5'd4: w = cb(CP);
               5'd5: w = cb(CE) | cb(LMDR);
               5'd6: w = cb(EA) | cb(LO);
               5'd7: w = cb(LB);
               5'd8: w = cb(LC);
               5'd9: w = cb(SU);
               default: w = '0;
            endcase
         default: w = '0;
      endcase
      return w;
   endfunction

   function automatic logic [15:0] wordAt(input logic [7:0] op, input logic [4:0] t);
      case (t)
         5'd0:    return cb(EP) | cb(LM);
         5'd1:    return cb(CP);
         5'd2:    return cb(CE) | cb(LI);
         default: return execWord(op, t);
      endcase
   endfunction

endpackage

// File: rtl/sap2_tstate_encoder.sv
// Converts the ring counter's one-hot T-state into a binary index (lowest set
// bit) together with any-bit-set and more-than-one-bit-set flags.
module sap2_tstate_encoder #(
   parameter int T_W = 18
) (
   input  logic [T_W-1:0] tState,
   output logic [4:0]     index,
   output logic           valid,
   output logic           multi
);

   always_comb begin
      index = '0;
      valid = |tState;
      multi = (tState & (tState - T_W'(1))) != '0;
      for (int i = T_W - 1; i >= 0; i--) begin
         if (tState[i]) index = 5'(i);
      end
   end

endmodule

// File: rtl/sap2_control_sequencer.sv
// SAP-2 control sequencer: registered control word, variable-length ring
// restart, halt/illegal tracking and retire count. Optional: RING_ONEHOT_CHECK_EN.
module sap2_control_sequencer
   import sap2_ctrl_pkg::*;
#(
   parameter int T_W   = 18,
   parameter int CW_W  = 16,
   parameter int RET_W = 16
) (
   input  logic             iClk,
   input  logic             iReset_n,
   input  logic [T_W-1:0]   iTState,
   input  logic [7:0]       iOpcode,
   output logic [CW_W-1:0]  oCtrl,
   output logic             oRingRst,
   output logic             oHalted,
   output logic             oIllegal,
`ifdef RING_ONEHOT_CHECK_EN
   output logic             oRingFault,
`endif
   output logic [RET_W-1:0] oRetired
);

   seqState_e state, stateNext;
   logic [4:0]      tIndex;
   logic            tValid, tMulti, known;
   logic [7:0]      opEff;
   logic [4:0]      lenM1;
   logic [15:0]     tableWord;
   logic [CW_W-1:0] ctrlNext;
   logic            ringRstNext, retireNext, illegalNext;

   sap2_tstate_encoder #(.T_W(T_W)) uEncoder (
      .tState (iTState),
      .index  (tIndex),
      .valid  (tValid),
      .multi  (tMulti)
   );

   // Unknown opcodes run as NOP; a multi-hot ring ORs every selected word.
   always_comb begin
      known     = isKnownOp(iOpcode);
      opEff     = known ? iOpcode : OP_NOP;
      lenM1     = instrLen(opEff) - 5'd1;
      tableWord = '0;
      if (tMulti) begin
         for (int t = 0; t < T_W; t++) begin
            if (iTState[t]) tableWord = tableWord | wordAt(opEff, 5'(t));
         end
      end else if (tValid) begin
         tableWord = wordAt(opEff, tIndex);
      end

      stateNext   = state;
      ctrlNext    = CW_W'(tableWord);
      ringRstNext = iTState[lenM1] | iTState[T_W-1];
      retireNext  = iTState[lenM1];
      illegalNext = oIllegal | (tValid && (tIndex >= 5'd3) && !known);

      case (state)
         sRun: begin
            if (tValid && !tMulti && (tIndex == 5'd4) && (opEff == OP_HLT))
               stateNext = sHalt;
         end
         sHalt: begin
            ctrlNext    = '0;
            ringRstNext = 1'b1;
            retireNext  = 1'b0;
            illegalNext = oIllegal;
         end
         sFault: begin
            if (iTState == T_W'(1)) begin
               stateNext = sRun;
            end else begin
               ctrlNext    = '0;
               ringRstNext = 1'b1;
               retireNext  = 1'b0;
               illegalNext = oIllegal;
            end
         end
         default: stateNext = sRun;
      endcase

`ifdef RING_ONEHOT_CHECK_EN
      if ((state != sHalt) && tMulti) begin
         stateNext   = sFault;
         ctrlNext    = '0;
         ringRstNext = 1'b1;
         retireNext  = 1'b0;
         illegalNext = oIllegal;
      end
`endif
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         state    <= sRun;
         oCtrl    <= '0;
         oRingRst <= 1'b0;
         oHalted  <= 1'b0;
         oIllegal <= 1'b0;
         oRetired <= '0;
      end else begin
         state    <= stateNext;
         oCtrl    <= ctrlNext;
         oRingRst <= ringRstNext;
         oHalted  <= (stateNext == sHalt);
         oIllegal <= illegalNext;
         if (retireNext) oRetired <= oRetired + RET_W'(1);
      end
   end

`ifdef RING_ONEHOT_CHECK_EN
   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) oRingFault <= 1'b0;
      else if (tMulti && (state != sHalt)) oRingFault <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_sap2_control_sequencer.sv
// Directed bench for sap2_control_sequencer: fetch/execute words, restart,
// HLT, illegal opcodes, mid-instruction reset, retire wrap and ring faults.
module tb_sap2_control_sequencer;

   logic        iClk = 1'b0;
   logic        iReset_n;
   logic [17:0] iTState;
   logic [7:0]  iOpcode;
   logic [15:0] oCtrl;
   logic        oRingRst, oHalted, oIllegal;
   logic [15:0] oRetired;
`ifdef RING_ONEHOT_CHECK_EN
   logic        oRingFault;
`endif

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   localparam logic [15:0] W_T0   = 16'hA000;
   localparam logic [15:0] W_T1   = 16'h4000;
   localparam logic [15:0] W_T2   = 16'h1800;
   localparam logic [15:0] W_MVI3 = 16'hA000;
   localparam logic [15:0] W_MVI4 = 16'h1002;
   localparam logic [15:0] W_MVI5 = 16'h4000;
   localparam logic [15:0] W_MVI6 = 16'h0201;
   localparam logic [15:0] W_ADD3 = 16'h0240;
   localparam logic [15:0] W_JMP5 = 16'h1002;

   sap2_control_sequencer dut (
      .iClk     (iClk),
      .iReset_n (iReset_n),
      .iTState  (iTState),
      .iOpcode  (iOpcode),
      .oCtrl    (oCtrl),
      .oRingRst (oRingRst),
      .oHalted  (oHalted),
      .oIllegal (oIllegal),
`ifdef RING_ONEHOT_CHECK_EN
      .oRingFault (oRingFault),
`endif
      .oRetired (oRetired)
   );

   always #5 iClk = ~iClk;

   // Inputs change on the falling edge like the ring; outputs read 1 after rise.
   task automatic applyStimulus(input logic [17:0] tState, input logic [7:0] op);
      @(negedge iClk);
      iTState = tState;
      iOpcode = op;
      @(posedge iClk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAllClear(input string tag);
      checkOutput({tag, " ctrl"},    32'(oCtrl),    32'h0);
      checkOutput({tag, " ringRst"}, 32'(oRingRst), 32'h0);
      checkOutput({tag, " halted"},  32'(oHalted),  32'h0);
      checkOutput({tag, " illegal"}, 32'(oIllegal), 32'h0);
      checkOutput({tag, " retired"}, 32'(oRetired), 32'h0);
   endtask

   task automatic doReset();
      @(negedge iClk);
      iReset_n = 1'b0;
      iTState  = '0;
      iOpcode  = 8'h00;
      #2;
      iReset_n = 1'b1;
   endtask

   initial begin
      iReset_n = 1'b0;
      iTState  = '0;
      iOpcode  = 8'h00;
      #12;
      checkAllClear("reset");
      @(negedge iClk);
      iReset_n = 1'b1;

      applyStimulus(18'h00001, 8'h00);
      checkOutput("nop T0 ctrl", 32'(oCtrl), 32'(W_T0));
      checkOutput("nop T0 rst", 32'(oRingRst), 32'h0);
      applyStimulus(18'h00002, 8'h00);
      checkOutput("nop T1 ctrl", 32'(oCtrl), 32'(W_T1));
      applyStimulus(18'h00004, 8'h00);
      checkOutput("nop T2 ctrl", 32'(oCtrl), 32'(W_T2));
      checkOutput("nop T2 rst", 32'(oRingRst), 32'h0);
      applyStimulus(18'h00008, 8'h00);
      checkOutput("nop T3 ctrl", 32'(oCtrl), 32'h0);
      checkOutput("nop T3 rst", 32'(oRingRst), 32'h1);
      checkOutput("nop retired", 32'(oRetired), 32'h1);

      applyStimulus(18'h00000, 8'h00);
      checkOutput("idle ctrl", 32'(oCtrl), 32'h0);
      checkOutput("idle rst", 32'(oRingRst), 32'h0);
      checkOutput("idle retired", 32'(oRetired), 32'h1);

      applyStimulus(18'h00001, 8'h3E);
      checkOutput("mvi T0 rst", 32'(oRingRst), 32'h0);
      applyStimulus(18'h00002, 8'h3E);
      applyStimulus(18'h00004, 8'h3E);
      applyStimulus(18'h00008, 8'h3E);
      checkOutput("mvi T3 ctrl", 32'(oCtrl), 32'(W_MVI3));
      checkOutput("mvi T3 rst", 32'(oRingRst), 32'h0);
      applyStimulus(18'h00010, 8'h3E);
      checkOutput("mvi T4 ctrl", 32'(oCtrl), 32'(W_MVI4));
      applyStimulus(18'h00020, 8'h3E);
      checkOutput("mvi T5 ctrl", 32'(oCtrl), 32'(W_MVI5));
      checkOutput("mvi T5 rst", 32'(oRingRst), 32'h0);
      applyStimulus(18'h00040, 8'h3E);
      checkOutput("mvi T6 ctrl", 32'(oCtrl), 32'(W_MVI6));
      checkOutput("mvi T6 rst", 32'(oRingRst), 32'h1);
      checkOutput("mvi retired", 32'(oRetired), 32'h2);

      applyStimulus(18'h00008, 8'h80);
      checkOutput("add T3 ctrl", 32'(oCtrl), 32'(W_ADD3));
      checkOutput("add retired", 32'(oRetired), 32'h3);

      applyStimulus(18'h20000, 8'h00);
      checkOutput("wrap T17 rst", 32'(oRingRst), 32'h1);
      checkOutput("wrap T17 retired", 32'(oRetired), 32'h3);

      for (int t = 0; t < 4; t++) applyStimulus(18'(1) << t, 8'hFF);
      checkOutput("illegal flag", 32'(oIllegal), 32'h1);
      checkOutput("illegal T3 ctrl", 32'(oCtrl), 32'h0);
      checkOutput("illegal T3 rst", 32'(oRingRst), 32'h1);
      checkOutput("illegal retired", 32'(oRetired), 32'h4);
      for (int t = 0; t < 4; t++) applyStimulus(18'(1) << t, 8'h80);
      checkOutput("illegal sticky", 32'(oIllegal), 32'h1);
      checkOutput("add2 ctrl", 32'(oCtrl), 32'(W_ADD3));
      checkOutput("add2 retired", 32'(oRetired), 32'h5);

      for (int t = 0; t < 6; t++) applyStimulus(18'(1) << t, 8'hC3);
      checkOutput("jmp T5 ctrl", 32'(oCtrl), 32'(W_JMP5));
      checkOutput("jmp T5 rst", 32'(oRingRst), 32'h0);
      iReset_n = 1'b0;
      #1;
      checkAllClear("midreset");
      @(negedge iClk);
      iReset_n = 1'b1;

      applyStimulus(18'h00001, 8'h76);
      checkOutput("post-reset T0 ctrl", 32'(oCtrl), 32'(W_T0));
      checkOutput("post-reset T0 rst", 32'(oRingRst), 32'h0);
      for (int t = 1; t < 4; t++) applyStimulus(18'(1) << t, 8'h76);
      checkOutput("hlt T3 rst", 32'(oRingRst), 32'h0);
      checkOutput("hlt T3 halted", 32'(oHalted), 32'h0);
      applyStimulus(18'h00010, 8'h76);
      checkOutput("hlt T4 halted", 32'(oHalted), 32'h1);
      checkOutput("hlt T4 rst", 32'(oRingRst), 32'h1);
      checkOutput("hlt retired", 32'(oRetired), 32'h1);
      for (int i = 0; i < 50; i++) applyStimulus((i % 2 == 0) ? 18'h00001 : 18'h00008, 8'h00);
      checkOutput("halted ctrl", 32'(oCtrl), 32'h0);
      checkOutput("halted rst", 32'(oRingRst), 32'h1);
      checkOutput("halted retired", 32'(oRetired), 32'h1);
      checkOutput("halted sticky", 32'(oHalted), 32'h1);

      doReset();
      #1;
      checkOutput("halt cleared", 32'(oHalted), 32'h0);
      for (int i = 0; i < 65535; i++) applyStimulus(18'h00008, 8'h00);
      checkOutput("retired all-ones", 32'(oRetired), 32'hFFFF);
      applyStimulus(18'h00008, 8'h00);
      checkOutput("retired wrap", 32'(oRetired), 32'h0);

      doReset();
`ifdef RING_ONEHOT_CHECK_EN
      applyStimulus(18'h00003, 8'h00);
      checkOutput("fault flag", 32'(oRingFault), 32'h1);
      checkOutput("fault ctrl", 32'(oCtrl), 32'h0);
      checkOutput("fault rst", 32'(oRingRst), 32'h1);
      applyStimulus(18'h00002, 8'h00);
      checkOutput("fault hold ctrl", 32'(oCtrl), 32'h0);
      checkOutput("fault hold rst", 32'(oRingRst), 32'h1);
      applyStimulus(18'h00001, 8'h00);
      checkOutput("fault recover ctrl", 32'(oCtrl), 32'(W_T0));
      checkOutput("fault recover rst", 32'(oRingRst), 32'h0);
      checkOutput("fault sticky", 32'(oRingFault), 32'h1);
`else
      applyStimulus(18'h00003, 8'h00);
      checkOutput("multihot OR ctrl", 32'(oCtrl), 32'(W_T0 | W_T1));
      checkOutput("multihot rst", 32'(oRingRst), 32'h0);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
